// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC register and decode.
// Ports: clk, rst_n (async, active-low); redirect/redirect_pc restart fetch;
//   imem_req/imem_addr/imem_gnt issue word requests, imem_rvalid/imem_rdata return
//   them in order; if_valid/if_pc/if_instr/if_ready hand {pc, instr} to decode.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt and perf_discard_cnt outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;
  logic [31:0] fetch_pc;
  logic [CW-1:0] outstanding, out_next, discard, discard_next, fifo_count;
  logic [CW:0] load;
  logic [31:0] aq [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [31:0] ins_q [DEPTH];
  logic [PW-1:0] aq_wr, aq_rd, wr_ptr, rd_ptr;
  logic grant, drop, push, pop;
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign grant = imem_req & imem_gnt;
  // A response in the redirect cycle belongs to the old stream, so it is dropped too.
  assign drop = imem_rvalid & (redirect | (discard != '0));
  assign push = imem_rvalid & ~drop;
  assign pop = if_valid & if_ready;
  assign out_next = outstanding + CW'(grant) - CW'(imem_rvalid);
  assign discard_next = redirect ? out_next : (drop ? discard - CW'(1) : discard);
  assign load = {1'b0, outstanding} + {1'b0, fifo_count};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (redirect) state_next = (out_next == '0) ? RUN : DRAIN;
    else if (state == IDLE) state_next = RUN;
    else if (state == DRAIN && discard_next == '0) state_next = RUN;
  end
  always_comb begin
    imem_req = (state == RUN) && (load < (CW+1)'(DEPTH));
    imem_addr = fetch_pc;
    if_valid = fifo_count != '0;
    if_pc = pc_q[rd_ptr];
    if_instr = ins_q[rd_ptr];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
      fifo_count <= '0;
      aq_wr <= '0;
      aq_rd <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        aq[i] <= '0;
        pc_q[i] <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      outstanding <= out_next;
      discard <= discard_next;
      if (redirect) fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (grant) begin
        aq[aq_wr] <= fetch_pc;
        aq_wr <= aq_wr + PW'(1);
      end
      // Every response, kept or dropped, retires its address queue entry.
      if (imem_rvalid) aq_rd <= aq_rd + PW'(1);
      if (push) begin
        pc_q[wr_ptr] <= aq[aq_rd];
        ins_q[wr_ptr] <= imem_rdata;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (redirect) begin
        rd_ptr <= wr_ptr;
        fifo_count <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end
`ifdef IF_PERF_CNT_EN
  // An entry popped in the redirect cycle was delivered, so it is not counted as flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_discard_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_discard_cnt <= perf_discard_cnt + 32'(drop) +
                          (redirect ? 32'(fifo_count) - 32'(pop) : 32'd0);
    end
  end
`endif
`ifndef SYNTHESIS
  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> outstanding != '0)
    else $error("imem_rvalid with no outstanding request");
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (directed table, corner sequences, random vs queue model).
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0, rst_n = 1'b0, redirect = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
  int n_chk = 0, n_fail = 0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_discard_cnt;
`endif
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_discard_cnt(perf_discard_cnt)
`endif
  );
  typedef struct packed {
    logic [3:0]  in;
    logic [31:0] rpc;
    logic [1:0]  ov;
    logic [31:0] addr;
    logic [31:0] pc;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    int ep;
    int due;
  } pend_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  vec_t tbl [28];
  logic [31:0] gq [$];
  pend_t pend [$];
  ent_t outq [$];
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic g, input logic rv, input logic rdy, input logic rd, input logic [31:0] rpc);
    imem_gnt = g;
    imem_rvalid = rv;
    if_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    imem_rdata = '0;
    if (rv && gq.size() != 0) imem_rdata = memfn(gq.pop_front());
    if (imem_req && g) gq.push_back(imem_addr);
    @(negedge clk);
  endtask
  task automatic reset_dut();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    if_ready = 1'b0;
    redirect = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_pc"}, if_pc, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'd0);
  endtask
  initial begin
    bit g, rv, rdy, rd, idle, exp_req;
    int ep, stale, due;
    logic [31:0] nf, rpc, e_fetch, e_disc;
    pend_t p;
    // in = {gnt, rvalid, ready, redirect}; ov = {imem_req, if_valid}
    tbl[0]  = '{4'b1010, 32'h0,   2'b00, 32'h0,   32'h0};
    tbl[1]  = '{4'b1010, 32'h0,   2'b10, 32'h0,   32'h0};
    tbl[2]  = '{4'b1110, 32'h0,   2'b10, 32'h4,   32'h0};
    tbl[3]  = '{4'b1110, 32'h0,   2'b01, 32'h8,   32'h0};
    tbl[4]  = '{4'b1010, 32'h0,   2'b11, 32'h8,   32'h4};
    tbl[5]  = '{4'b1110, 32'h0,   2'b10, 32'hC,   32'h0};
    tbl[6]  = '{4'b1110, 32'h0,   2'b01, 32'h10,  32'h8};
    tbl[7]  = '{4'b1000, 32'h0,   2'b11, 32'h10,  32'hC};
    tbl[8]  = '{4'b0100, 32'h0,   2'b01, 32'h14,  32'hC};
    tbl[9]  = '{4'b0000, 32'h0,   2'b01, 32'h14,  32'hC};
    tbl[10] = '{4'b0000, 32'h0,   2'b01, 32'h14,  32'hC};
    tbl[11] = '{4'b0010, 32'h0,   2'b01, 32'h14,  32'hC};
    tbl[12] = '{4'b1010, 32'h0,   2'b11, 32'h14,  32'h10};
    tbl[13] = '{4'b0110, 32'h0,   2'b10, 32'h18,  32'h0};
    tbl[14] = '{4'b0000, 32'h0,   2'b11, 32'h18,  32'h14};
    tbl[15] = '{4'b0000, 32'h0,   2'b11, 32'h18,  32'h14};
    tbl[16] = '{4'b0001, 32'h203, 2'b11, 32'h18,  32'h14};
    tbl[17] = '{4'b1010, 32'h0,   2'b10, 32'h200, 32'h0};
    tbl[18] = '{4'b0110, 32'h0,   2'b10, 32'h204, 32'h0};
    tbl[19] = '{4'b1010, 32'h0,   2'b11, 32'h204, 32'h200};
    tbl[20] = '{4'b1010, 32'h0,   2'b10, 32'h208, 32'h0};
    tbl[21] = '{4'b1001, 32'h100, 2'b00, 32'h20C, 32'h0};
    tbl[22] = '{4'b0100, 32'h0,   2'b00, 32'h100, 32'h0};
    tbl[23] = '{4'b0000, 32'h0,   2'b00, 32'h100, 32'h0};
    tbl[24] = '{4'b0100, 32'h0,   2'b00, 32'h100, 32'h0};
    tbl[25] = '{4'b1010, 32'h0,   2'b10, 32'h100, 32'h0};
    tbl[26] = '{4'b0110, 32'h0,   2'b10, 32'h104, 32'h0};
    tbl[27] = '{4'b0010, 32'h0,   2'b11, 32'h104, 32'h100};
    #1;
    chk_reset("reset");
    @(negedge clk);
    reset_dut();
    for (int i = 0; i < 28; i++) begin
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].ov[1]));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].ov[0]));
      if (tbl[i].ov[0]) begin
        chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), if_instr, memfn(tbl[i].pc));
      end
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], tbl[i].rpc);
    end
`ifdef IF_PERF_CNT_EN
    chk("tbl_perf_fetch", perf_fetch_cnt, 32'd7);
    chk("tbl_perf_discard", perf_discard_cnt, 32'd3);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_req0", 32'(imem_req), 32'd1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_req1", 32'(imem_req), 32'd1);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_valid", 32'(if_valid), 32'd1);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", if_instr, memfn(32'hFFFF_FFFC));
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    reset_dut();
    idle = 1'b1;
    ep = 0;
    nf = RESET_PC;
    e_fetch = '0;
    e_disc = '0;
    pend.delete();
    outq.delete();
    for (int c = 0; c < 3000; c++) begin
      stale = 0;
      foreach (pend[i]) if (pend[i].ep != ep) stale++;
      exp_req = !idle && stale == 0 && (pend.size() + outq.size() < DEPTH);
      chk("rnd_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("rnd_addr", imem_addr, nf);
      chk("rnd_valid", 32'(if_valid), 32'(outq.size() != 0));
      if (outq.size() != 0) begin
        chk("rnd_pc", if_pc, outq[0].pc);
        chk("rnd_instr", if_instr, outq[0].ins);
      end
`ifdef IF_PERF_CNT_EN
      chk("rnd_perf_fetch", perf_fetch_cnt, e_fetch);
      chk("rnd_perf_discard", perf_discard_cnt, e_disc);
`endif
      g = $urandom_range(0, 3) != 0;
      rv = pend.size() != 0 && pend[0].due <= c;
      rdy = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 19) == 0;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : ($urandom & 32'h0000_0FFF);
      if (outq.size() != 0 && rdy) begin
        void'(outq.pop_front());
        e_fetch++;
      end
      p = '{32'h0, 0, 0};
      if (rv) begin
        p = pend.pop_front();
        if (p.ep == ep) outq.push_back('{p.addr, memfn(p.addr)});
        else e_disc++;
      end
      if (imem_req && g) begin
        due = c + 1 + int'($urandom_range(0, 3));
        if (pend.size() != 0 && pend[pend.size()-1].due > due) due = pend[pend.size()-1].due;
        pend.push_back('{nf, ep, due});
        nf += 32'd4;
      end
      if (rd) begin
        e_disc += 32'(outq.size());
        outq.delete();
        ep++;
        nf = {rpc[31:2], 2'b00};
      end
      idle = 1'b0;
      imem_gnt = g;
      imem_rvalid = rv;
      if_ready = rdy;
      redirect = rd;
      redirect_pc = rpc;
      imem_rdata = rv ? memfn(p.addr) : 32'h0;
      @(negedge clk);
    end
    reset_dut();
    chk("drain_idle_req", 32'(imem_req), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_req0", 32'(imem_req), 32'd1);
    chk("drain_addr0", imem_addr, RESET_PC);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr1", imem_addr, RESET_PC + 32'd4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_full_req", 32'(imem_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    chk("drain_req", 32'(imem_req), 32'd0);
    chk("drain_addr", imem_addr, 32'h40);
    #2 rst_n = 1'b0;
    #1 chk_reset("drain_rst");
    @(negedge clk);
    reset_dut();
    chk("post_idle_req", 32'(imem_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_req", 32'(imem_req), 32'd1);
    chk("post_addr", imem_addr, RESET_PC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
